// File: rtl/merge_pkg.sv
// Shared types for the two-way merge engine: FSM state encoding and run-length width helper.
`timescale 1ns / 1ps
package merge_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StMerge,
        StDrainL,
        StDrainR,
        StFlush
    } merge_state_t;

    // Width needed to hold a run length of 0..max_len inclusive.
    function automatic int unsigned len_width(input int unsigned max_len);
        return $clog2(max_len + 1);
    endfunction

endpackage

// File: rtl/merge_out_reg.sv
// Single-entry output slot with valid/ready handshake; contents hold while stalled.
`timescale 1ns / 1ps
module merge_out_reg #(
    parameter int unsigned KEY_W = 16,
    parameter int unsigned TAG_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [KEY_W-1:0] load_key,
    input  logic [TAG_W-1:0] load_tag,
    input  logic             load_last,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [KEY_W-1:0] out_key,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_last,
    output logic             slot_free
);

    logic             valid_q;
    logic [KEY_W-1:0] key_q;
    logic [TAG_W-1:0] tag_q;
    logic             last_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            key_q   <= '0;
            tag_q   <= '0;
            last_q  <= 1'b0;
        end else if (load) begin
            valid_q <= 1'b1;
            key_q   <= load_key;
            tag_q   <= load_tag;
            last_q  <= load_last;
        end else if (out_ready) begin
            // Slot drained with nothing new: drop valid and the stale last marker.
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end
    end

    assign out_valid = valid_q;
    assign out_key   = key_q;
    assign out_tag   = tag_q;
    assign out_last  = last_q;
    assign slot_free = !valid_q || out_ready;

endmodule

// File: rtl/merge_unit.sv
// Two-way stable merge of sorted (key, tag) runs into one run with a last marker.
// Define MERGE_DESC_EN to honour the desc input; otherwise the merge is always ascending.
`timescale 1ns / 1ps
module merge_unit
    import merge_pkg::*;
#(
    parameter int unsigned KEY_W   = 16,
    parameter int unsigned TAG_W   = 8,
    parameter int unsigned MAX_LEN = 16,
    localparam int unsigned LEN_W  = len_width(MAX_LEN)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] len_l,
    input  logic [LEN_W-1:0] len_r,
    input  logic             desc,
    input  logic             l_valid,
    output logic             l_ready,
    input  logic [KEY_W-1:0] l_key,
    input  logic [TAG_W-1:0] l_tag,
    input  logic             r_valid,
    output logic             r_ready,
    input  logic [KEY_W-1:0] r_key,
    input  logic [TAG_W-1:0] r_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [KEY_W-1:0] out_key,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_last,
    output logic             busy,
    output logic             done
);

    typedef struct packed {
        logic [KEY_W-1:0] key;
        logic [TAG_W-1:0] tag;
    } elem_t;

    localparam logic [LEN_W-1:0] MaxLenSat = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] One       = LEN_W'(1);

    merge_state_t     state_q, state_d;
    logic [LEN_W-1:0] rem_l_q, rem_l_d, rem_r_q, rem_r_d;
    logic [LEN_W-1:0] len_l_sat, len_r_sat;
    logic             done_q, done_d;
    logic             dir;
    logic             pick_l, slot_free, load, load_last;
    elem_t            l_elem, r_elem, load_elem;

`ifdef MERGE_DESC_EN
    logic dir_q, dir_d;
    assign dir = dir_q;
`else
    logic unused_desc;
    assign unused_desc = desc;
    assign dir         = 1'b0;
`endif

    assign len_l_sat = (len_l > MaxLenSat) ? MaxLenSat : len_l;
    assign len_r_sat = (len_r > MaxLenSat) ? MaxLenSat : len_r;
    assign l_elem    = {l_key, l_tag};
    assign r_elem    = {r_key, r_tag};
    // Ties go left in both directions, which keeps the merge stable.
    assign pick_l    = dir ? (l_key >= r_key) : (l_key <= r_key);

    always_comb begin
        state_d   = state_q;
        rem_l_d   = rem_l_q;
        rem_r_d   = rem_r_q;
        done_d    = 1'b0;
        l_ready   = 1'b0;
        r_ready   = 1'b0;
        load_last = 1'b0;
        load_elem = l_elem;
`ifdef MERGE_DESC_EN
        dir_d     = dir_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    rem_l_d = len_l_sat;
                    rem_r_d = len_r_sat;
`ifdef MERGE_DESC_EN
                    dir_d   = desc;
`endif
                    if (len_l_sat != '0 && len_r_sat != '0) state_d = StMerge;
                    else if (len_l_sat != '0)               state_d = StDrainL;
                    else if (len_r_sat != '0)               state_d = StDrainR;
                    else                                    state_d = StFlush;
                end
            end
            StMerge: begin
                if (l_valid && r_valid && slot_free) begin
                    if (pick_l) begin
                        l_ready = 1'b1;
                        rem_l_d = rem_l_q - One;
                        if (rem_l_q == One) state_d = StDrainR;
                    end else begin
                        r_ready   = 1'b1;
                        load_elem = r_elem;
                        rem_r_d   = rem_r_q - One;
                        if (rem_r_q == One) state_d = StDrainL;
                    end
                end
            end
            StDrainL: begin
                if (l_valid && slot_free) begin
                    l_ready   = 1'b1;
                    rem_l_d   = rem_l_q - One;
                    load_last = (rem_l_q == One);
                    if (rem_l_q == One) state_d = StFlush;
                end
            end
            StDrainR: begin
                if (r_valid && slot_free) begin
                    r_ready   = 1'b1;
                    load_elem = r_elem;
                    rem_r_d   = rem_r_q - One;
                    load_last = (rem_r_q == One);
                    if (rem_r_q == One) state_d = StFlush;
                end
            end
            StFlush: begin
                // An empty slot here means a zero-length merge with nothing to wait for.
                if (!out_valid || (out_ready && out_last)) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign load = l_ready || r_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            rem_l_q <= '0;
            rem_r_q <= '0;
            done_q  <= 1'b0;
`ifdef MERGE_DESC_EN
            dir_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            rem_l_q <= rem_l_d;
            rem_r_q <= rem_r_d;
            done_q  <= done_d;
`ifdef MERGE_DESC_EN
            dir_q   <= dir_d;
`endif
        end
    end

    assign busy = (state_q != StIdle);
    assign done = done_q;

    merge_out_reg #(
        .KEY_W(KEY_W),
        .TAG_W(TAG_W)
    ) u_out_reg (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .load_key  (load_elem.key),
        .load_tag  (load_elem.tag),
        .load_last (load_last),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_key   (out_key),
        .out_tag   (out_tag),
        .out_last  (out_last),
        .slot_free (slot_free)
    );

endmodule
